pipe_reg_multi: RTL and testbench
=================================

Name: pipe_reg_multi

Overview:
- Parametrised, multi-lane, multi-stage pipeline register carrying write-back bundles (wr_en, dst, data, data-valid) between execution and write-back.
- Generalises the single-stage, two-signal-set EX->WB register. Adds configurable depth and lane count, per-entry valid, stall (hold), flush (bubble), an in-flight counter and a conflict flag.
- Sits between any EX-side producer and the WB / register-file write port.

Parameters:
- NUM_LANES, 2, number of parallel write-back lanes; 1..4.
- DEPTH, 1, number of register stages (latency); 1..8. DEPTH=0 is an elaboration error.
- ADRS_W, RF_ADRS_W (package), register-file address width.
- DATA_W, DATA_W (package), data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all stages; input not captured.
- flush  in  1  invalidate all stages; input not captured.
- in_valid  in  NUM_LANES  lane entry present.
- in_wr_en  in  NUM_LANES  lane requests RF write.
- in_dst  in  NUM_LANES x ADRS_W  destination register.
- in_data  in  NUM_LANES x DATA_W  result data.
- in_datav  in  NUM_LANES  data-valid qualifier.
- out_valid  out  NUM_LANES  final-stage valid.
- out_wr_en  out  NUM_LANES  final-stage write enable (already gated by valid).
- out_dst  out  NUM_LANES x ADRS_W  final-stage destination.
- out_data  out  NUM_LANES x DATA_W  final-stage data.
- out_datav  out  NUM_LANES  final-stage data-valid (gated by valid).
- out_conflict  out  1  two or more valid final-stage lanes write the same dst.
- inflight_cnt  out  $clog2(NUM_LANES*DEPTH+1)  number of valid lane-entries across all stages.

Behaviour:
- Reset (reset=1 at posedge):
  - all stage valid, wr_en and datav bits go to 0; dst and data go to 0.
  - out_* are 0, out_conflict=0, inflight_cnt=0 from the next cycle.
  - reset has priority over flush and stall.
- Capture: on a posedge with reset=0, flush=0, stall=0:
  - stage0 <= input; stage k <= stage k-1.
  - stored wr_en = in_valid & in_wr_en; stored datav = in_valid & in_datav.
  - dst and data are captured unconditionally.
- Latency: input presented at cycle t appears on out_* at cycle t+DEPTH, provided there is no stall. Each stall cycle adds one cycle.
- Stall: all stages hold, including dst and data. out_* are stable for the whole stall.
- Flush: all valid, wr_en and datav bits are cleared in every stage; the input is dropped; dst and data are don't-care. Flush wins over stall when both are asserted.
- Lane order: a higher lane index is younger within a stage. No reordering across lanes or stages.
- out_conflict (combinational from the final stage):
  - asserted if any pair i<j has out_wr_en[i] & out_wr_en[j] & out_dst[i]==out_dst[j].
  - the WB side gives the higher lane priority; this block only flags the conflict.
- inflight_cnt: registered. Equals the popcount of all stage valid bits after the edge.
  - 0 after reset or flush.
  - maximum NUM_LANES*DEPTH; no wrap is possible.
- Outputs are register-driven except out_conflict and the forwarding outputs.
- Lanes with in_valid=0 propagate as bubbles and are counted as empty.

Optional Feature:
- Macro PIPE_REG_FWD_EN.
- When defined, adds the following ports:
  - fwd_src in ADRS_W
  - fwd_hit out 1
  - fwd_data out DATA_W
  - fwd_datav out 1
- A combinational search runs over all stages and lanes for entries with valid & wr_en & dst==fwd_src.
  - The youngest match wins: lowest stage index, then highest lane index.
  - fwd_hit=1 on a match, and fwd_data/fwd_datav come from the winning entry.
  - With no match, all three outputs are 0.
  - During flush the search still reflects the current (pre-flush) contents.
- When not defined, these ports do not exist and there is no search logic.

Decomposition:
- Shared package holds:
  - RF_ADRS_W and DATA_W constants and the t_RFadrs / t_data typedefs.
  - struct t_wb_entry {valid, wr_en, dst, data, datav}.
  - MAX_LANES and MAX_DEPTH constants.
- One natural sub-module: pipe_reg_stage, a single NUM_LANES-wide stage with hold/clear, instantiated DEPTH times in a generate loop.
- The forwarding priority search stays in the top module.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0, out_wr_en=0, inflight_cnt=0. Deassert reset, apply no input -> outputs stay 0.
- Latency: DEPTH=3, NUM_LANES=2; at t=0 apply lane0 dst=5 data=0xA5A5 wr_en=1 -> out appears at t=3 with lane0 valid, dst=5, data=0xA5A5; inflight_cnt=1 during t=1..3.
- Stall: entry in flight, stall=1 for 2 cycles -> output arrives 2 cycles late and out_* are stable while stalled. A different input presented during the stall is not captured.
- Flush with simultaneous stall: 3 stages full (inflight_cnt=6), flush=1 and stall=1 -> next cycle inflight_cnt=0 and all out_valid=0. The input on the flush cycle never emerges.
- Conflict: lane0 and lane1 both dst=7 wr_en=1 -> out_conflict=1 when they reach the output. Same case with lane1 wr_en=0 -> out_conflict=0.
- PIPE_REG_FWD_EN build: dst=4 data=0x11 in stage2, dst=4 data=0x22 in stage0 lane1, fwd_src=4 -> fwd_hit=1, fwd_data=0x22. fwd_src=9 -> fwd_hit=0, fwd_data=0.

Source files
------------

// File: rtl/pipe_reg_multi_pkg.sv
// pipe_reg_multi_pkg: shared widths, types and limits for the write-back pipeline register.
package pipe_reg_multi_pkg;
  localparam int RF_ADRS_W = 5;
  localparam int DATA_W    = 32;
  localparam int MAX_LANES = 4;
  localparam int MAX_DEPTH = 8;
  typedef logic [RF_ADRS_W-1:0] t_RFadrs;
  typedef logic [DATA_W-1:0]    t_data;
  typedef struct packed {
    logic    valid;
    logic    wr_en;
    t_RFadrs dst;
    t_data   data;
    logic    datav;
  } t_wb_entry;
endpackage

// File: rtl/pipe_reg_multi_if.sv
// pipe_reg_multi_if: EX-side producer / WB-side bundle; forwarding signals exist only with PIPE_REG_FWD_EN.
interface pipe_reg_multi_if #(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 1,
  parameter int ADRS_W    = pipe_reg_multi_pkg::RF_ADRS_W,
  parameter int DATA_W    = pipe_reg_multi_pkg::DATA_W
);
  localparam int CW = $clog2(NUM_LANES*DEPTH+1);
  logic                              stall;
  logic                              flush;
  logic [NUM_LANES-1:0]              in_valid;
  logic [NUM_LANES-1:0]              in_wr_en;
  logic [NUM_LANES-1:0][ADRS_W-1:0]  in_dst;
  logic [NUM_LANES-1:0][DATA_W-1:0]  in_data;
  logic [NUM_LANES-1:0]              in_datav;
  logic [NUM_LANES-1:0]              out_valid;
  logic [NUM_LANES-1:0]              out_wr_en;
  logic [NUM_LANES-1:0][ADRS_W-1:0]  out_dst;
  logic [NUM_LANES-1:0][DATA_W-1:0]  out_data;
  logic [NUM_LANES-1:0]              out_datav;
  logic                              out_conflict;
  logic [CW-1:0]                     inflight_cnt;
`ifdef PIPE_REG_FWD_EN
  logic [ADRS_W-1:0]                 fwd_src;
  logic                              fwd_hit;
  logic [DATA_W-1:0]                 fwd_data;
  logic                              fwd_datav;
`endif
  modport master (
    output stall, flush, in_valid, in_wr_en, in_dst, in_data, in_datav,
    input  out_valid, out_wr_en, out_dst, out_data, out_datav, out_conflict, inflight_cnt
`ifdef PIPE_REG_FWD_EN
    , output fwd_src, input fwd_hit, fwd_data, fwd_datav
`endif
  );
  modport slave (
    input  stall, flush, in_valid, in_wr_en, in_dst, in_data, in_datav,
    output out_valid, out_wr_en, out_dst, out_data, out_datav, out_conflict, inflight_cnt
`ifdef PIPE_REG_FWD_EN
    , input fwd_src, output fwd_hit, fwd_data, fwd_datav
`endif
  );
endinterface

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: one NUM_LANES-wide write-back stage with hold (stall) and clear (flush).
module pipe_reg_stage
  import pipe_reg_multi_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int ADRS_W    = pipe_reg_multi_pkg::RF_ADRS_W,
  parameter int DATA_W    = pipe_reg_multi_pkg::DATA_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             hold,
  input  logic                             clear,
  input  logic [NUM_LANES-1:0]             i_valid,
  input  logic [NUM_LANES-1:0]             i_wr_en,
  input  logic [NUM_LANES-1:0][ADRS_W-1:0] i_dst,
  input  logic [NUM_LANES-1:0][DATA_W-1:0] i_data,
  input  logic [NUM_LANES-1:0]             i_datav,
  output logic [NUM_LANES-1:0]             o_valid,
  output logic [NUM_LANES-1:0]             o_wr_en,
  output logic [NUM_LANES-1:0][ADRS_W-1:0] o_dst,
  output logic [NUM_LANES-1:0][DATA_W-1:0] o_data,
  output logic [NUM_LANES-1:0]             o_datav
);
  always_ff @(posedge clock) begin
    if (reset) begin
      o_valid <= '0;
      o_wr_en <= '0;
      o_datav <= '0;
      o_dst   <= '0;
      o_data  <= '0;
    end else if (clear) begin
      o_valid <= '0;
      o_wr_en <= '0;
      o_datav <= '0;
    end else if (!hold) begin
      o_valid <= i_valid;
      o_wr_en <= i_valid & i_wr_en;
      o_datav <= i_valid & i_datav;
      o_dst   <= i_dst;
      o_data  <= i_data;
    end
  end
endmodule

// File: rtl/pipe_reg_multi.sv
// pipe_reg_multi: DEPTH-stage, NUM_LANES-wide EX->WB register with stall/flush, in-flight count,
// conflict flag and an optional youngest-match forwarding search (macro PIPE_REG_FWD_EN).
module pipe_reg_multi
  import pipe_reg_multi_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 1,
  parameter int ADRS_W    = pipe_reg_multi_pkg::RF_ADRS_W,
  parameter int DATA_W    = pipe_reg_multi_pkg::DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  pipe_reg_multi_if.slave  bus
);
  localparam int CW = $clog2(NUM_LANES*DEPTH+1);
  if (NUM_LANES < 1 || NUM_LANES > MAX_LANES || DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_cfg
    $error("pipe_reg_multi: NUM_LANES must be 1..%0d and DEPTH 1..%0d", MAX_LANES, MAX_DEPTH);
  end
  // index 0 is the input side, index s+1 is the output of stage s
  logic [NUM_LANES-1:0]             w_valid [DEPTH+1];
  logic [NUM_LANES-1:0]             w_wr_en [DEPTH+1];
  logic [NUM_LANES-1:0]             w_datav [DEPTH+1];
  logic [NUM_LANES-1:0][ADRS_W-1:0] w_dst   [DEPTH+1];
  logic [NUM_LANES-1:0][DATA_W-1:0] w_data  [DEPTH+1];
  logic [CW-1:0]                    w_nxt_cnt;
  logic [CW-1:0]                    r_cnt;
  logic                             w_conflict;
  assign w_valid[0] = bus.in_valid;
  assign w_wr_en[0] = bus.in_wr_en;
  assign w_datav[0] = bus.in_datav;
  assign w_dst[0]   = bus.in_dst;
  assign w_data[0]  = bus.in_data;
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    pipe_reg_stage #(.NUM_LANES(NUM_LANES), .ADRS_W(ADRS_W), .DATA_W(DATA_W)) u_stage (
      .clock   (clock),
      .reset   (reset),
      .hold    (bus.stall),
      .clear   (bus.flush),
      .i_valid (w_valid[s]),
      .i_wr_en (w_wr_en[s]),
      .i_dst   (w_dst[s]),
      .i_data  (w_data[s]),
      .i_datav (w_datav[s]),
      .o_valid (w_valid[s+1]),
      .o_wr_en (w_wr_en[s+1]),
      .o_dst   (w_dst[s+1]),
      .o_data  (w_data[s+1]),
      .o_datav (w_datav[s+1])
    );
  end
  // after a capture the stages hold the input plus stages 0..DEPTH-2
  always_comb begin
    w_nxt_cnt = '0;
    for (int s = 0; s < DEPTH; s++)
      for (int l = 0; l < NUM_LANES; l++)
        w_nxt_cnt = w_nxt_cnt + CW'(w_valid[s][l]);
  end
  always_ff @(posedge clock) begin
    if (reset || bus.flush) r_cnt <= '0;
    else if (!bus.stall) r_cnt <= w_nxt_cnt;
  end
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      for (int j = i + 1; j < NUM_LANES; j++)
        w_conflict = w_conflict | (w_wr_en[DEPTH][i] & w_wr_en[DEPTH][j] &
                                   (w_dst[DEPTH][i] == w_dst[DEPTH][j]));
  end
  assign bus.out_valid    = w_valid[DEPTH];
  assign bus.out_wr_en    = w_wr_en[DEPTH];
  assign bus.out_dst      = w_dst[DEPTH];
  assign bus.out_data     = w_data[DEPTH];
  assign bus.out_datav    = w_datav[DEPTH];
  assign bus.out_conflict = w_conflict;
  assign bus.inflight_cnt = r_cnt;
`ifdef PIPE_REG_FWD_EN
  logic              w_hit;
  logic [DATA_W-1:0] w_fdata;
  logic              w_fdatav;
  // scan oldest to youngest so the last match (lowest stage, highest lane) wins
  always_comb begin
    w_hit    = 1'b0;
    w_fdata  = '0;
    w_fdatav = 1'b0;
    for (int s = DEPTH; s >= 1; s--)
      for (int l = 0; l < NUM_LANES; l++)
        if (w_valid[s][l] && w_wr_en[s][l] && w_dst[s][l] == bus.fwd_src) begin
          w_hit    = 1'b1;
          w_fdata  = w_data[s][l];
          w_fdatav = w_datav[s][l];
        end
  end
  assign bus.fwd_hit   = w_hit;
  assign bus.fwd_data  = w_fdata;
  assign bus.fwd_datav = w_fdatav;
`endif
endmodule

// File: tb/tb_pipe_reg_multi.sv
// tb_pipe_reg_multi: directed + random scoreboard bench for pipe_reg_multi (NUM_LANES=2, DEPTH=3).
module tb_pipe_reg_multi;
  import pipe_reg_multi_pkg::*;
  localparam int NL = 2;
  localparam int D  = 3;
  typedef t_wb_entry [NL-1:0] t_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  t_stage q[$];
  always #5 clock = ~clock;
  pipe_reg_multi_if #(.NUM_LANES(NL), .DEPTH(D), .ADRS_W(RF_ADRS_W), .DATA_W(DATA_W)) bus ();
  pipe_reg_multi #(.NUM_LANES(NL), .DEPTH(D)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_out();
    t_stage e;
    logic [NL-1:0] ev, ew, ed;
    logic ec;
    int n;
`ifdef PIPE_REG_FWD_EN
    logic fh;
    t_data fd;
    logic fv;
`endif
    e = q[0];
    ec = 1'b0;
    n = 0;
    for (int l = 0; l < NL; l++) begin
      ev[l] = e[l].valid;
      ew[l] = e[l].wr_en;
      ed[l] = e[l].datav;
    end
    foreach (q[s]) for (int l = 0; l < NL; l++) n += int'(q[s][l].valid);
    for (int i = 0; i < NL; i++)
      for (int j = i + 1; j < NL; j++)
        if (ew[i] && ew[j] && e[i].dst == e[j].dst) ec = 1'b1;
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("out_wr_en", 64'(bus.out_wr_en), 64'(ew));
    chk("out_datav", 64'(bus.out_datav), 64'(ed));
    chk("out_conflict", 64'(bus.out_conflict), 64'(ec));
    chk("inflight_cnt", 64'(bus.inflight_cnt), 64'(n));
    for (int l = 0; l < NL; l++)
      if (ev[l]) begin
        chk("out_dst", 64'(bus.out_dst[l]), 64'(e[l].dst));
        chk("out_data", 64'(bus.out_data[l]), 64'(e[l].data));
      end
`ifdef PIPE_REG_FWD_EN
    fh = 1'b0;
    fd = '0;
    fv = 1'b0;
    for (int s = 0; s < D; s++)
      for (int l = 0; l < NL; l++)
        if (q[s][l].valid && q[s][l].wr_en && q[s][l].dst == bus.fwd_src) begin
          fh = 1'b1;
          fd = q[s][l].data;
          fv = q[s][l].datav;
        end
    chk("fwd_hit", 64'(bus.fwd_hit), 64'(fh));
    chk("fwd_data", 64'(bus.fwd_data), 64'(fd));
    chk("fwd_datav", 64'(bus.fwd_datav), 64'(fv));
`endif
  endtask
  task automatic step(input logic r, st, fl, input logic [NL-1:0] v, we, dv,
                      input t_RFadrs d0, d1, input t_data x0, x1);
    t_stage n;
    reset = r;
    bus.stall = st;
    bus.flush = fl;
    bus.in_valid = v;
    bus.in_wr_en = we;
    bus.in_datav = dv;
    bus.in_dst[0] = d0;
    bus.in_dst[1] = d1;
    bus.in_data[0] = x0;
    bus.in_data[1] = x1;
    @(posedge clock);
    if (r || fl) begin
      q.delete();
      repeat (D) q.push_back('0);
    end else if (!st) begin
      for (int l = 0; l < NL; l++) begin
        n[l].valid = v[l];
        n[l].wr_en = v[l] & we[l];
        n[l].datav = v[l] & dv[l];
        n[l].dst   = l == 0 ? d0 : d1;
        n[l].data  = l == 0 ? x0 : x1;
      end
      q.push_back(n);
      void'(q.pop_front());
    end
    #1 check_out();
  endtask
  task automatic idle();
    step(0, 0, 0, '0, '0, '0, '0, '0, '0, '0);
  endtask
  initial begin
    repeat (D) q.push_back('0);
`ifdef PIPE_REG_FWD_EN
    bus.fwd_src = 5'd4;
`endif
    step(1, 0, 0, '0, '0, '0, '0, '0, '0, '0);
    step(1, 1, 1, 2'b11, 2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
    chk("rst_dst", 64'(bus.out_dst), 64'h0);
    chk("rst_data", 64'(bus.out_data), 64'h0);
    repeat (3) idle();
    // latency
    step(0, 0, 0, 2'b01, 2'b01, 2'b01, 5'd5, 5'd0, 32'hA5A5, 32'h0);
    chk("lat_cnt_t1", 64'(bus.inflight_cnt), 64'd1);
    repeat (2) idle();
    chk("lat_dst", 64'(bus.out_dst[0]), 64'd5);
    chk("lat_data", 64'(bus.out_data[0]), 64'hA5A5);
    idle();
    // stall with a different input presented
    step(0, 0, 0, 2'b10, 2'b10, 2'b10, 5'd0, 5'd3, 32'h0, 32'h33);
    idle();
    step(0, 1, 0, 2'b11, 2'b11, 2'b11, 5'd9, 5'd9, 32'hBAD, 32'hBAD);
    step(0, 1, 0, 2'b11, 2'b11, 2'b11, 5'd9, 5'd9, 32'hBAD, 32'hBAD);
    repeat (4) idle();
    // fill, then flush together with stall
    step(0, 0, 0, 2'b11, 2'b11, 2'b11, 5'd1, 5'd2, 32'h10, 32'h20);
    step(0, 0, 0, 2'b11, 2'b01, 2'b10, 5'd3, 5'd4, 32'h30, 32'h40);
    step(0, 0, 0, 2'b11, 2'b10, 2'b11, 5'd5, 5'd6, 32'h50, 32'h60);
    chk("full_cnt", 64'(bus.inflight_cnt), 64'd6);
    step(0, 1, 1, 2'b11, 2'b11, 2'b11, 5'd7, 5'd8, 32'h70, 32'h80);
    chk("flush_cnt", 64'(bus.inflight_cnt), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) idle();
    // conflict
    step(0, 0, 0, 2'b11, 2'b11, 2'b11, 5'd7, 5'd7, 32'hC0, 32'hC1);
    repeat (2) idle();
    chk("conflict_on", 64'(bus.out_conflict), 64'd1);
    step(0, 0, 0, 2'b11, 2'b01, 2'b11, 5'd7, 5'd7, 32'hC2, 32'hC3);
    repeat (2) idle();
    chk("conflict_off", 64'(bus.out_conflict), 64'd0);
    // forwarding scenario: dst 4 in stage2 and in stage0 lane1
    step(0, 0, 0, 2'b01, 2'b01, 2'b01, 5'd4, 5'd0, 32'h11, 32'h0);
    idle();
    step(0, 0, 0, 2'b11, 2'b10, 2'b10, 5'd1, 5'd4, 32'h99, 32'h22);
`ifdef PIPE_REG_FWD_EN
    #1;
    chk("fwd_hit_4", 64'(bus.fwd_hit), 64'd1);
    chk("fwd_data_4", 64'(bus.fwd_data), 64'h22);
    bus.fwd_src = 5'd9;
    #1;
    chk("fwd_hit_9", 64'(bus.fwd_hit), 64'd0);
    chk("fwd_data_9", 64'(bus.fwd_data), 64'd0);
    bus.fwd_src = 5'd4;
`endif
    repeat (3) idle();
    // random traffic
    for (int k = 0; k < 60; k++) begin
`ifdef PIPE_REG_FWD_EN
      bus.fwd_src = 5'($urandom_range(0, 7));
`endif
      step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           2'($urandom), 2'($urandom), 2'($urandom),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
    end
    repeat (D) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
